// File: rtl/pll_seq_ctrl.sv
// pll_seq_ctrl: sequences a PLL through bypass, power-down, ratio load,
// enable and lock qualification, then holds it in RUN until lock is lost
// or a new configuration request arrives.
//
// The enable, bypass and ratio outputs are registered and decided by the
// transition being taken, so while the state register holds X, the outputs
// already show the values that belong to X. locked, err and req_ready are
// plain decodes of the state register.
module pll_seq_ctrl #(
  parameter int SETTLE_CYC   = 16,
  parameter int LOCK_STABLE  = 8,
  parameter int LOCK_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [9:0] req_ratio,
  input  logic [9:0] req_zdiv0,
  input  logic [9:0] req_zdiv1,
  input  logic [1:0] req_vcodiv,
  input  logic       lock,
  output logic       pllen,
  output logic       bypass,
  output logic [9:0] ratio,
  output logic [9:0] zdiv0_ratio,
  output logic [9:0] zdiv1_ratio,
  output logic [1:0] vcodiv_ratio,
  output logic       locked,
  output logic       err,
  output logic [1:0] err_code
);

  // Counter width and the effective limits. A limit of zero would make a
  // state last no time at all, so it is promoted to one; limits larger
  // than the counter can express are clipped so the compare stays reachable.
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam int SETTLE_EFF  = (SETTLE_CYC < 1) ? 1 :
                               ((SETTLE_CYC > CNT_MAX) ? CNT_MAX : SETTLE_CYC);
  localparam int STABLE_EFF  = (LOCK_STABLE < 1) ? 1 :
                               ((LOCK_STABLE > CNT_MAX) ? CNT_MAX : LOCK_STABLE);
  localparam int TIMEOUT_EFF = (LOCK_TIMEOUT < 1) ? 1 :
                               ((LOCK_TIMEOUT > CNT_MAX) ? CNT_MAX : LOCK_TIMEOUT);

  localparam logic [CNT_W-1:0] SETTLE_LIM  = CNT_W'(SETTLE_EFF);
  localparam logic [CNT_W-1:0] STABLE_LIM  = CNT_W'(STABLE_EFF);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_EFF);

  // Error codes reported on err_code.
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_LOST    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_BYPASS    = 3'd1,
    S_PWRDN     = 3'd2,
    S_LOAD      = 3'd3,
    S_ENABLE    = 3'd4,
    S_WAIT_LOCK = 3'd5,
    S_RUN       = 3'd6,
    S_ERROR     = 3'd7
  } state_e;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == {CNT_W{1'b1}}) ? value : value + CNT_W'(1);
  endfunction

  state_e           state;
  state_e           state_next;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] cyc_next;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] stable_next;
  logic             pllen_next;
  logic             bypass_next;
  logic [1:0]       err_code_next;
  logic             load_en;
  logic             accept;

  logic             lock_meta;
  logic             lock_sync;

  logic [9:0]       sh_ratio;
  logic [9:0]       sh_zdiv0;
  logic [9:0]       sh_zdiv1;
  logic [1:0]       sh_vcodiv;

  // Requests are only taken in the resting states; anything else is dropped.
  assign req_ready = (state == S_IDLE) || (state == S_RUN) || (state == S_ERROR);
  assign accept    = req_valid && req_ready;
  assign locked    = (state == S_RUN);
  assign err       = (state == S_ERROR);

  // Two-flop synchroniser for the raw lock, which is asynchronous to clk.
  // NOTE: sequential blocks use non-blocking assignments so every flop
  // samples the pre-edge value of its source, giving a true two-stage chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= lock;
      lock_sync <= lock_meta;
    end
  end

  // Shadow copy of the request, held until the LOAD cycle publishes it.
  // NOTE: these are pure data registers with no reset; they are always
  // written on acceptance before LOAD can read them, so a reset would only
  // add routing without changing behaviour.
  always_ff @(posedge clk) begin
    if (accept) begin
      sh_ratio  <= req_ratio;
      sh_zdiv0  <= req_zdiv0;
      sh_zdiv1  <= req_zdiv1;
      sh_vcodiv <= req_vcodiv;
    end
  end

  // State, counters and the registered PLL control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cyc_cnt    <= '0;
      stable_cnt <= '0;
      pllen      <= 1'b0;
      bypass     <= 1'b1;
      err_code   <= ERR_NONE;
    end else begin
      state      <= state_next;
      cyc_cnt    <= cyc_next;
      stable_cnt <= stable_next;
      pllen      <= pllen_next;
      bypass     <= bypass_next;
      err_code   <= err_code_next;
    end
  end

  // Ratio outputs: updated on the edge that enters LOAD and held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ratio        <= '0;
      zdiv0_ratio  <= '0;
      zdiv1_ratio  <= '0;
      vcodiv_ratio <= '0;
    end else if (load_en) begin
      ratio        <= sh_ratio;
      zdiv0_ratio  <= sh_zdiv0;
      zdiv1_ratio  <= sh_zdiv1;
      vcodiv_ratio <= sh_vcodiv;
    end
  end

  // Next-state logic; output values are set on the transition into a state.
  // cyc_cnt times PWRDN and then the WAIT_LOCK timeout; stable_cnt counts
  // consecutive lock_sync-high cycles in WAIT_LOCK.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    cyc_next      = cyc_cnt;
    stable_next   = stable_cnt;
    pllen_next    = pllen;
    bypass_next   = bypass;
    err_code_next = err_code;
    load_en       = 1'b0;

    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next  = S_BYPASS;
          bypass_next = 1'b1;
        end
      end

      // pllen is left alone here so a running PLL keeps its clock while
      // the downstream logic is moved onto the bypass path.
      S_BYPASS: begin
        state_next = S_PWRDN;
        pllen_next = 1'b0;
        cyc_next   = '0;
      end

      S_PWRDN: begin
        if (cyc_cnt >= SETTLE_LIM - CNT_W'(1)) begin
          state_next = S_LOAD;
          load_en    = 1'b1;
          cyc_next   = '0;
        end else begin
          cyc_next = sat_inc(cyc_cnt);
        end
      end

      S_LOAD: begin
        state_next = S_ENABLE;
        pllen_next = 1'b1;
      end

      S_ENABLE: begin
        state_next  = S_WAIT_LOCK;
        cyc_next    = '0;
        stable_next = '0;
      end

      // Lock qualification is tested before the timeout, so a lock that
      // completes on the last allowed cycle still wins.
      S_WAIT_LOCK: begin
        stable_next = lock_sync ? sat_inc(stable_cnt) : '0;
        cyc_next    = sat_inc(cyc_cnt);
        if (stable_next >= STABLE_LIM) begin
          state_next  = S_RUN;
          pllen_next  = 1'b1;
          bypass_next = 1'b0;
        end else if (cyc_next >= TIMEOUT_LIM) begin
          state_next    = S_ERROR;
          pllen_next    = 1'b0;
          bypass_next   = 1'b1;
          err_code_next = ERR_TIMEOUT;
        end
      end

      // A new request outranks a simultaneous loss of lock.
      S_RUN: begin
        if (accept) begin
          state_next  = S_BYPASS;
          bypass_next = 1'b1;
        end else if (!lock_sync) begin
          state_next    = S_ERROR;
          pllen_next    = 1'b0;
          bypass_next   = 1'b1;
          err_code_next = ERR_LOST;
        end
      end

      S_ERROR: begin
        if (accept) begin
          state_next    = S_BYPASS;
          bypass_next   = 1'b1;
          err_code_next = ERR_NONE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// tb_pll_seq_ctrl: directed bench for pll_seq_ctrl. A timeline model
// (phases stamped with the edge they began on) predicts every output on
// every cycle; literal expectations at hand-computed edge offsets pin it.
module tb_pll_seq_ctrl;

  localparam int SETTLE  = 16;
  localparam int STABLE  = 8;
  localparam int TIMEOUT = 1023;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b1;
  logic       req_valid  = 1'b0;
  logic [9:0] req_ratio  = '0;
  logic [9:0] req_zdiv0  = '0;
  logic [9:0] req_zdiv1  = '0;
  logic [1:0] req_vcodiv = '0;
  logic       lock       = 1'b0;

  logic       req_ready;
  logic       pllen;
  logic       bypass;
  logic [9:0] ratio;
  logic [9:0] zdiv0_ratio;
  logic [9:0] zdiv1_ratio;
  logic [1:0] vcodiv_ratio;
  logic       locked;
  logic       err;
  logic [1:0] err_code;

  pll_seq_ctrl #(
    .SETTLE_CYC  (SETTLE),
    .LOCK_STABLE (STABLE),
    .LOCK_TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_ratio   (req_ratio),
    .req_zdiv0   (req_zdiv0),
    .req_zdiv1   (req_zdiv1),
    .req_vcodiv  (req_vcodiv),
    .lock        (lock),
    .pllen       (pllen),
    .bypass      (bypass),
    .ratio       (ratio),
    .zdiv0_ratio (zdiv0_ratio),
    .zdiv1_ratio (zdiv1_ratio),
    .vcodiv_ratio(vcodiv_ratio),
    .locked      (locked),
    .err         (err),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  typedef enum int {P_IDLE, P_BYPASS, P_PWRDN, P_LOAD, P_ENABLE, P_WAIT, P_RUN, P_ERROR} phase_e;

  phase_e     ph       = P_IDLE;
  int         edge_n   = 0;   // rising edges seen out of reset
  int         ph_start = 0;   // edge on which the current phase began
  int         last_low = 0;   // latest WAIT edge on which synced lock was low
  int         age      = 0;
  bit         seen1    = 1'b0; // raw lock as sampled one edge back
  bit         seen2    = 1'b0; // raw lock as sampled two edges back
  bit         m_ls     = 1'b0;
  bit         m_acc    = 1'b0;
  logic [9:0] sh_ratio = '0, sh_z0 = '0, sh_z1 = '0;
  logic [1:0] sh_vc    = '0;
  logic       e_pllen  = 1'b0;
  logic       e_bypass = 1'b1;
  logic [9:0] e_ratio  = '0, e_z0 = '0, e_z1 = '0;
  logic [1:0] e_vc     = '0;
  logic [1:0] e_code   = 2'b00;
  logic       m_ready;

  assign m_ready = (ph == P_IDLE) || (ph == P_RUN) || (ph == P_ERROR);

  // Model process: decisions at an edge use the lock level from two edges
  // earlier; phase lengths come from edge-stamp differences.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      ph = P_IDLE; seen1 = 1'b0; seen2 = 1'b0;
      e_pllen = 1'b0; e_bypass = 1'b1; e_code = 2'b00;
      e_ratio = '0; e_z0 = '0; e_z1 = '0; e_vc = '0;
    end else begin
      edge_n++;
      m_ls  = seen2;
      seen2 = seen1;
      seen1 = lock;
      m_acc = req_valid && m_ready;
      age   = edge_n - ph_start;
      case (ph)
        P_IDLE, P_RUN, P_ERROR: begin
          if (m_acc) begin
            sh_ratio = req_ratio; sh_z0 = req_zdiv0; sh_z1 = req_zdiv1; sh_vc = req_vcodiv;
            e_code = 2'b00; e_bypass = 1'b1;
            ph = P_BYPASS; ph_start = edge_n;
          end else if (ph == P_RUN && !m_ls) begin
            e_pllen = 1'b0; e_bypass = 1'b1; e_code = 2'b10;
            ph = P_ERROR; ph_start = edge_n;
          end
        end
        P_BYPASS: begin
          e_pllen = 1'b0; ph = P_PWRDN; ph_start = edge_n;
        end
        P_PWRDN: begin
          if (age == SETTLE) begin
            e_ratio = sh_ratio; e_z0 = sh_z0; e_z1 = sh_z1; e_vc = sh_vc;
            ph = P_LOAD; ph_start = edge_n;
          end
        end
        P_LOAD: begin
          e_pllen = 1'b1; ph = P_ENABLE; ph_start = edge_n;
        end
        P_ENABLE: begin
          last_low = edge_n; ph = P_WAIT; ph_start = edge_n;
        end
        P_WAIT: begin
          if (!m_ls) last_low = edge_n;
          if (edge_n - last_low >= STABLE) begin
            e_pllen = 1'b1; e_bypass = 1'b0; ph = P_RUN; ph_start = edge_n;
          end else if (age >= TIMEOUT) begin
            e_pllen = 1'b0; e_bypass = 1'b1; e_code = 2'b01; ph = P_ERROR; ph_start = edge_n;
          end
        end
        default: ph = P_IDLE;
      endcase
    end
  end

  logic [38:0] dut_obs;
  logic [38:0] exp_obs;
  assign dut_obs = {req_ready, pllen, bypass, ratio, zdiv0_ratio, zdiv1_ratio,
                    vcodiv_ratio, locked, err, err_code};
  assign exp_obs = {m_ready, e_pllen, e_bypass, e_ratio, e_z0, e_z1,
                    e_vc, (ph == P_RUN), (ph == P_ERROR), e_code};

  // Per-cycle comparison against the model, away from the rising edge.
  initial forever begin
    @(negedge clk);
    check("cycle", 64'(dut_obs), 64'(exp_obs));
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_n(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Presents a request for one edge; returns on the negedge after that edge.
  task automatic issue(input logic [9:0] r, input logic [9:0] z0,
                       input logic [9:0] z1, input logic [1:0] vc);
    req_ratio = r; req_zdiv0 = z0; req_zdiv1 = z1; req_vcodiv = vc;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    wait_n(2);
    check("rst_pllen",  64'(pllen),    64'd0);
    check("rst_bypass", 64'(bypass),   64'd1);
    check("rst_ratio",  64'(ratio),    64'd0);
    check("rst_locked", 64'(locked),   64'd0);
    check("rst_err",    64'(err),      64'd0);
    check("rst_code",   64'(err_code), 64'd0);
    rst_n = 1'b1;
    wait_n(1);
    check("rst_exit_ready", 64'(req_ready), 64'd1);

    // Nominal bring-up: ratio 40 / 2 / 4 / 1, lock raised once ENABLE shows.
    issue(10'd40, 10'd2, 10'd4, 2'd1);
    check("nom_bypass_first", 64'(bypass), 64'd1);
    check("nom_not_ready",    64'(req_ready), 64'd0);
    wait_n(1);
    check("nom_pwrdn_pllen", 64'(pllen), 64'd0);
    wait_n(15);
    check("nom_pwrdn_last_pllen", 64'(pllen), 64'd0);
    check("nom_ratio_held",       64'(ratio), 64'd0);
    wait_n(1);
    check("nom_load_ratio",  64'(ratio),        64'd40);
    check("nom_load_zdiv0",  64'(zdiv0_ratio),  64'd2);
    check("nom_load_zdiv1",  64'(zdiv1_ratio),  64'd4);
    check("nom_load_vcodiv", 64'(vcodiv_ratio), 64'd1);
    check("nom_load_pllen",  64'(pllen),        64'd0);
    wait_n(1);
    check("nom_enable_pllen", 64'(pllen), 64'd1);
    lock = 1'b1;
    wait_n(9);
    check("nom_not_yet_locked", 64'(locked), 64'd0);
    wait_n(1);
    check("nom_locked", 64'(locked), 64'd1);
    check("nom_bypass_off", 64'(bypass), 64'd0);
    check("nom_run_ready", 64'(req_ready), 64'd1);

    // Lock drops and a request arrives on the same RUN edge: request wins.
    lock = 1'b0;
    wait_n(2);
    issue(10'd50, 10'd6, 10'd8, 2'd2);
    check("prio_req_no_err",   64'(err),    64'd0);
    check("prio_req_bypass",   64'(bypass), 64'd1);
    check("prio_bypass_pllen", 64'(pllen),  64'd1);
    // Glitch: 5 edges high, 1 low, then high again; blocked request in WAIT.
    wait_n(18);
    lock = 1'b1;
    wait_n(2);
    req_ratio = 10'd999; req_zdiv0 = 10'd999; req_zdiv1 = 10'd999; req_vcodiv = 2'd3;
    req_valid = 1'b1;
    wait_n(2);
    req_valid = 1'b0;
    wait_n(1);
    lock = 1'b0;
    wait_n(1);
    lock = 1'b1;
    wait_n(4);
    check("glitch_restart", 64'(locked), 64'd0);
    wait_n(5);
    check("glitch_not_yet", 64'(locked), 64'd0);
    wait_n(1);
    check("glitch_locked",  64'(locked), 64'd1);
    check("blocked_ratio",  64'(ratio),  64'd50);
    check("blocked_zdiv0",  64'(zdiv0_ratio), 64'd6);

    // Lock lost in RUN.
    lock = 1'b0;
    wait_n(2);
    check("loss_still_run", 64'(locked), 64'd1);
    wait_n(1);
    check("loss_err",    64'(err),      64'd1);
    check("loss_code",   64'(err_code), 64'd2);
    check("loss_bypass", 64'(bypass),   64'd1);
    check("loss_pllen",  64'(pllen),    64'd0);

    // New request from ERROR clears it; lock stays low so it times out.
    issue(10'd7, 10'd3, 10'd5, 2'd2);
    check("clr_err",  64'(err),      64'd0);
    check("clr_code", 64'(err_code), 64'd0);
    wait_n(1041);
    check("tmo_not_yet", 64'(err),   64'd0);
    check("tmo_ratio",   64'(ratio), 64'd7);
    wait_n(1);
    check("tmo_err",    64'(err),      64'd1);
    check("tmo_code",   64'(err_code), 64'd1);
    check("tmo_pllen",  64'(pllen),    64'd0);
    check("tmo_bypass", 64'(bypass),   64'd1);

    // Lock qualifies on exactly the timeout edge: lock must win.
    issue(10'd100, 10'd9, 10'd10, 2'd3);
    wait_n(1032);
    lock = 1'b1;
    wait_n(9);
    check("edge_not_yet", 64'(locked), 64'd0);
    wait_n(1);
    check("edge_locked", 64'(locked),   64'd1);
    check("edge_no_err", 64'(err),      64'd0);
    check("edge_code",   64'(err_code), 64'd0);

    // Reset pulsed during PWRDN.
    issue(10'd11, 10'd1, 10'd1, 2'd0);
    wait_n(5);
    check("mid_pwrdn_pllen", 64'(pllen), 64'd0);
    check("mid_ratio_held",  64'(ratio), 64'd100);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_bypass", 64'(bypass),    64'd1);
    check("mid_rst_ratio",  64'(ratio),     64'd0);
    check("mid_rst_vcodiv", 64'(vcodiv_ratio), 64'd0);
    check("mid_rst_ready",  64'(req_ready), 64'd1);
    wait_n(1);
    rst_n = 1'b1;
    wait_n(1);
    check("mid_exit_ready", 64'(req_ready), 64'd1);
    check("mid_exit_pllen", 64'(pllen),     64'd0);
    wait_n(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
